conv_stream_feeder: RTL and testbench

- Producer-side sequencer for the convolution line-buffer chain.
- Accepts one image frame as a raster-order pixel stream over a valid/ready handshake.
- Drives the shift-buffer enable/data pair, one pixel per accepted beat.
- Tracks row/column position and flags which shifts complete a full filterWidth x filterWidth window, so the downstream MAC stage knows when to fire.

---
 rtl/conv_stream_feeder_if.sv | 29 ++
 rtl/conv_stream_feeder.sv | 121 ++++++++++++
 tb/tb_conv_stream_feeder.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/conv_stream_feeder_if.sv
// Handshake/bus bundle between the pixel source and the convolution stream feeder.
// The slave modport is the feeder side; master is the source/observer side.
interface conv_stream_feeder_if #(
  parameter int bitwidth = 8,
  parameter int CW       = 4,
  parameter int RW       = 4
);
  logic                start;
  logic                in_valid;
  logic [bitwidth-1:0] in_data;
  logic                in_ready;
  logic                shift_enable;
  logic [bitwidth-1:0] shift_data;
  logic                window_valid;
  logic [RW-1:0]       row;
  logic [CW-1:0]       col;
  logic                busy;
  logic                frame_done;

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, shift_enable, shift_data, window_valid, row, col, busy, frame_done
  );

  modport master (
    output start, in_valid, in_data,
    input  in_ready, shift_enable, shift_data, window_valid, row, col, busy, frame_done
  );
endinterface

// File: rtl/conv_stream_feeder.sv
// Raster-order pixel sequencer feeding the conv line-buffer chain, flagging full windows.
// Optional macro FEEDER_STRIDE2_EN restricts window_valid to a stride-2 output grid.
module conv_stream_feeder #(
  parameter int bitwidth    = 8,
  parameter int imageWidth  = 11,
  parameter int imageHeight = 11,
  parameter int filterWidth = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  conv_stream_feeder_if.slave  bus
);
  localparam int CW = (imageWidth  > 1) ? $clog2(imageWidth)  : 1;
  localparam int RW = (imageHeight > 1) ? $clog2(imageHeight) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(imageWidth - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(imageHeight - 1);
  localparam logic [CW-1:0] COL_MIN  = CW'(filterWidth - 1);
  localparam logic [RW-1:0] ROW_MIN  = RW'(filterWidth - 1);

  typedef enum logic [0:0] {IDLE, STREAM} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       col_cnt_q, col_cnt_d;
  logic [RW-1:0]       row_cnt_q, row_cnt_d;
  logic                shift_enable_q, shift_enable_d;
  logic [bitwidth-1:0] shift_data_q, shift_data_d;
  logic                window_valid_q, window_valid_d;
  logic [RW-1:0]       row_q, row_d;
  logic [CW-1:0]       col_q, col_d;
  logic                frame_done_q, frame_done_d;

  logic accept, last_pix, col_wrap, win_hit;

  assign accept   = (state_q == STREAM) && bus.in_valid;
  assign col_wrap = (col_cnt_q == COL_LAST);
  assign last_pix = col_wrap && (row_cnt_q == ROW_LAST);

`ifdef FEEDER_STRIDE2_EN
  // (cnt - MIN) is even exactly when the LSBs agree
  assign win_hit = (row_cnt_q >= ROW_MIN) && (col_cnt_q >= COL_MIN) &&
                   (row_cnt_q[0] == ROW_MIN[0]) && (col_cnt_q[0] == COL_MIN[0]);
`else
  assign win_hit = (row_cnt_q >= ROW_MIN) && (col_cnt_q >= COL_MIN);
`endif

  always_comb begin
    state_d        = state_q;
    col_cnt_d      = col_cnt_q;
    row_cnt_d      = row_cnt_q;
    shift_enable_d = 1'b0;
    shift_data_d   = shift_data_q;
    window_valid_d = 1'b0;
    row_d          = row_q;
    col_d          = col_q;
    frame_done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = STREAM;
          col_cnt_d = '0;
          row_cnt_d = '0;
        end
      end
      STREAM: begin
        if (accept) begin
          shift_enable_d = 1'b1;
          shift_data_d   = bus.in_data;
          row_d          = row_cnt_q;
          col_d          = col_cnt_q;
          window_valid_d = win_hit;
          if (last_pix) begin
            frame_done_d = 1'b1;
            state_d      = IDLE;
            col_cnt_d    = '0;
            row_cnt_d    = '0;
          end else if (col_wrap) begin
            col_cnt_d = '0;
            row_cnt_d = row_cnt_q + 1'b1;
          end else begin
            col_cnt_d = col_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      col_cnt_q      <= '0;
      row_cnt_q      <= '0;
      shift_enable_q <= 1'b0;
      shift_data_q   <= '0;
      window_valid_q <= 1'b0;
      row_q          <= '0;
      col_q          <= '0;
      frame_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      col_cnt_q      <= col_cnt_d;
      row_cnt_q      <= row_cnt_d;
      shift_enable_q <= shift_enable_d;
      shift_data_q   <= shift_data_d;
      window_valid_q <= window_valid_d;
      row_q          <= row_d;
      col_q          <= col_d;
      frame_done_q   <= frame_done_d;
    end
  end

  assign bus.in_ready     = (state_q == STREAM);
  assign bus.busy         = (state_q == STREAM);
  assign bus.shift_enable = shift_enable_q;
  assign bus.shift_data   = shift_data_q;
  assign bus.window_valid = window_valid_q;
  assign bus.row          = row_q;
  assign bus.col          = col_q;
  assign bus.frame_done   = frame_done_q;
endmodule

// File: tb/tb_conv_stream_feeder.sv
// Scoreboard bench for conv_stream_feeder: a frame-position model queues expected shifts,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_conv_stream_feeder;
  localparam int BW = 8;
  localparam int W  = 11;
  localparam int H  = 11;
  localparam int FW = 3;
  localparam int N  = W * H;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam int RW = (H > 1) ? $clog2(H) : 1;

  typedef struct {
    logic [BW-1:0] data;
    int            row;
    int            col;
    bit            win;
    bit            fd;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv_stream_feeder_if #(.bitwidth(BW), .CW(CW), .RW(RW)) bus ();

  conv_stream_feeder #(.bitwidth(BW), .imageWidth(W), .imageHeight(H), .filterWidth(FW)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  exp_t q[$];
  bit   m_stream = 0;
  int   m_idx = 0;
  bit   mon_en = 0;
  logic [BW-1:0] last_data = '0;
  int   last_row = 0, last_col = 0;
  int   shift_cnt = 0, win_cnt = 0, fd_cnt = 0;
  int   n_chk = 0, n_fail = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit exp_win(int r, int c);
    bit w;
    w = (r >= FW - 1) && (c >= FW - 1);
`ifdef FEEDER_STRIDE2_EN
    w = w && ((r - (FW - 1)) % 2 == 0) && ((c - (FW - 1)) % 2 == 0);
`endif
    return w;
  endfunction

  // One clock: drive at negedge, advance the reference model at the following posedge.
  task automatic cycle(bit st, bit v, logic [BW-1:0] d, bit r = 0);
    exp_t e;
    @(negedge clk);
    rst = r; bus.start = st; bus.in_valid = v; bus.in_data = d;
    @(posedge clk);
    if (r) begin
      m_stream = 0; m_idx = 0; q.delete();
      last_data = '0; last_row = 0; last_col = 0;
    end else if (m_stream) begin
      if (v) begin
        e.data = d; e.row = m_idx / W; e.col = m_idx % W;
        e.win = exp_win(e.row, e.col); e.fd = (m_idx == N - 1);
        q.push_back(e);
        m_idx++;
        if (m_idx == N) begin m_stream = 0; m_idx = 0; end
      end
    end else if (st) begin
      m_stream = 1;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      chk("in_ready", bus.in_ready, m_stream);
      chk("busy", bus.busy, m_stream);
      chk("shift_enable", bus.shift_enable, q.size() != 0);
      if (bus.shift_enable === 1'b1 && q.size() != 0) begin
        e = q.pop_front();
        chk("shift_data", bus.shift_data, e.data);
        chk("row", bus.row, e.row);
        chk("col", bus.col, e.col);
        chk("window_valid", bus.window_valid, e.win);
        chk("frame_done", bus.frame_done, e.fd);
        last_data = e.data; last_row = e.row; last_col = e.col;
        shift_cnt++;
        if (bus.window_valid === 1'b1) win_cnt++;
        if (bus.frame_done === 1'b1) fd_cnt++;
      end else if (bus.shift_enable !== 1'b1) begin
        chk("hold_data", bus.shift_data, last_data);
        chk("hold_row", bus.row, last_row);
        chk("hold_col", bus.col, last_col);
        chk("idle_window_valid", bus.window_valid, 0);
        chk("idle_frame_done", bus.frame_done, 0);
      end
    end
  end

  // mode: 0 back-to-back, 1 alternating gaps, 2 random gaps, 3 back-to-back with stray starts
  task automatic run_frame(int mode);
    int guard;
    int exp_w;
    bit v, st;
    logic [BW-1:0] d;
    shift_cnt = 0; win_cnt = 0; fd_cnt = 0;
    exp_w = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        if (exp_win(r, c)) exp_w++;
    cycle(1, 0, '0);
    guard = 0;
    while (m_stream && guard < 4 * N) begin
      case (mode)
        1:       v = guard[0];
        2:       v = ($urandom_range(0, 3) != 0);
        default: v = 1;
      endcase
      d  = (mode == 0) ? BW'(m_idx) : BW'($urandom);
      st = (mode == 3) && (m_idx == 60 || m_idx == N - 1);
      cycle(st, v, d);
      guard++;
    end
    chk("frame_timeout", guard < 4 * N, 1);
    for (int i = 0; i < 3; i++) cycle(0, 1, 8'h5A);
    chk("frame_shifts", shift_cnt, N);
    chk("frame_windows", win_cnt, exp_w);
    chk("frame_done_count", fd_cnt, 1);
    chk("queue_drained", q.size(), 0);
  endtask

  initial begin
    bus.start = 0; bus.in_valid = 0; bus.in_data = '0;
    cycle(0, 0, '0, 1);
    mon_en = 1;
    cycle(0, 0, '0, 0);

    run_frame(0);
    run_frame(1);

    for (int i = 0; i < 10; i++) cycle(0, 1, 8'h55);

    // abandon a frame mid-way with reset
    cycle(1, 0, '0);
    for (int i = 0; i < 50; i++) cycle(0, 1, BW'(i));
    cycle(0, 1, BW'(50), 1);
    cycle(0, 1, 8'h33);
    cycle(0, 0, '0);
    run_frame(0);

    run_frame(3);
    run_frame(2);

    cycle(0, 0, '0);
    chk("final_queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
